// File: rtl/tag_wakeup_array.sv
// -----------------------------------------------------------------------------
// tag_wakeup_array
//
// Reservation-station wakeup array. Holds ENTRIES pending instructions, each
// with two source tags. Every cycle the stored tags of waiting entries are
// compared against CDB_PORTS result broadcasts, and the matching operand-ready
// bits are latched. The lowest-index entry with both operands ready is
// offered to the issue stage through a valid/ready handshake.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset (dominates flush)
//   flush        squash: every entry goes FREE at the next edge
//   alloc_valid  dispatch requests an entry
//   alloc_ready  at least one entry FREE (from registered state)
//   alloc_tag_a  source A tag of the dispatched instruction
//   alloc_rdy_a  source A already available
//   alloc_tag_b  source B tag of the dispatched instruction
//   alloc_rdy_b  source B already available
//   alloc_idx    entry written when alloc fires (lowest FREE)
//   cdb_valid    per-port broadcast valid
//   cdb_tag      packed broadcast tags, port p at [p*TAG_W +: TAG_W]
//   issue_valid  some entry has both operands ready
//   issue_ready  issue stage accepts the offered entry
//   issue_idx    lowest-index READY entry
//   occupancy    number of non-FREE entries
// -----------------------------------------------------------------------------
module tag_wakeup_array #(
    parameter  int TAG_W     = 6,
    parameter  int ENTRIES   = 8,
    parameter  int CDB_PORTS = 2,
    localparam int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [TAG_W-1:0]           alloc_tag_a,
    input  logic                       alloc_rdy_a,
    input  logic [TAG_W-1:0]           alloc_tag_b,
    input  logic                       alloc_rdy_b,
    output logic [IDX_W-1:0]           alloc_idx,

    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,

    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [IDX_W-1:0]           issue_idx,

    output logic [IDX_W:0]             occupancy
);

    // Per-entry lifecycle states.
    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q [ENTRIES];
    logic [1:0]       state_d [ENTRIES];
    logic [TAG_W-1:0] tag_a_q [ENTRIES];
    logic [TAG_W-1:0] tag_a_d [ENTRIES];
    logic [TAG_W-1:0] tag_b_q [ENTRIES];
    logic [TAG_W-1:0] tag_b_d [ENTRIES];
    logic [ENTRIES-1:0] rdy_a_q, rdy_a_d;
    logic [ENTRIES-1:0] rdy_b_q, rdy_b_d;
    logic [IDX_W:0]     occ_q, occ_d;

    // -------------------------------------------------------------------------
    // Status vectors derived from registered state only
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] ready_vec;

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            free_vec[e]  = (state_q[e] == ST_FREE);
            ready_vec[e] = (state_q[e] == ST_READY);
        end
    end

    // Isolate the lowest set bit: x & (-x). These one-hot selects pick the
    // entry that alloc writes and the entry that issue frees.
    logic [ENTRIES-1:0] alloc_sel;
    logic [ENTRIES-1:0] issue_sel;

    assign alloc_sel = free_vec  & (~free_vec  + ENTRIES'(1));
    assign issue_sel = ready_vec & (~ready_vec + ENTRIES'(1));

    // Binary indices of the same lowest-set-bit choice. The descending scan
    // leaves the lowest matching index; 0 is presented when nothing matches.
    // NOTE: every variable driven in an always_comb gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (free_vec[e]) begin
                alloc_idx = IDX_W'(e);
            end
            if (ready_vec[e]) begin
                issue_idx = IDX_W'(e);
            end
        end
    end

    assign alloc_ready = |free_vec;
    assign issue_valid = |ready_vec;
    assign occupancy   = occ_q;

    logic alloc_fire;
    logic issue_fire;

    assign alloc_fire = alloc_valid && alloc_ready;
    assign issue_fire = issue_valid && issue_ready;

    // -------------------------------------------------------------------------
    // Tag compare against the CDB (OR-reduced across ports)
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0] hit_a;
    logic [ENTRIES-1:0] hit_b;
    logic               alloc_hit_a;
    logic               alloc_hit_b;

    // NOTE: blocking assignments are correct here: this is combinational
    // logic, and each OR accumulation must see the value written by the
    // previous loop iteration.
    always_comb begin
        hit_a       = '0;
        hit_b       = '0;
        alloc_hit_a = 1'b0;
        alloc_hit_b = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
                // Bypass path: catch a broadcast in the same cycle as the
                // dispatch so the operand can never miss its wakeup.
                if (cdb_tag[p*TAG_W +: TAG_W] == alloc_tag_a) begin
                    alloc_hit_a = 1'b1;
                end
                if (cdb_tag[p*TAG_W +: TAG_W] == alloc_tag_b) begin
                    alloc_hit_b = 1'b1;
                end
                for (int e = 0; e < ENTRIES; e++) begin
                    if (cdb_tag[p*TAG_W +: TAG_W] == tag_a_q[e]) begin
                        hit_a[e] = 1'b1;
                    end
                    if (cdb_tag[p*TAG_W +: TAG_W] == tag_b_q[e]) begin
                        hit_b[e] = 1'b1;
                    end
                end
            end
        end
    end

    logic new_rdy_a;
    logic new_rdy_b;

    assign new_rdy_a = alloc_rdy_a || alloc_hit_a;
    assign new_rdy_b = alloc_rdy_b || alloc_hit_b;

    // -------------------------------------------------------------------------
    // Per-entry next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            state_d[e] = state_q[e];
            tag_a_d[e] = tag_a_q[e];
            tag_b_d[e] = tag_b_q[e];
            rdy_a_d[e] = rdy_a_q[e];
            rdy_b_d[e] = rdy_b_q[e];

            if (flush) begin
                // Squash discards alloc, issue and wakeup of this cycle.
                state_d[e] = ST_FREE;
                rdy_a_d[e] = 1'b0;
                rdy_b_d[e] = 1'b0;
            end else begin
                case (state_q[e])
                    ST_FREE: begin
                        if (alloc_fire && alloc_sel[e]) begin
                            tag_a_d[e] = alloc_tag_a;
                            tag_b_d[e] = alloc_tag_b;
                            rdy_a_d[e] = new_rdy_a;
                            rdy_b_d[e] = new_rdy_b;
                            state_d[e] = (new_rdy_a && new_rdy_b) ? ST_READY : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        rdy_a_d[e] = rdy_a_q[e] || hit_a[e];
                        rdy_b_d[e] = rdy_b_q[e] || hit_b[e];
                        if ((rdy_a_q[e] || hit_a[e]) && (rdy_b_q[e] || hit_b[e])) begin
                            state_d[e] = ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (issue_fire && issue_sel[e]) begin
                            state_d[e] = ST_FREE;
                            rdy_a_d[e] = 1'b0;
                            rdy_b_d[e] = 1'b0;
                        end
                    end
                    default: begin
                        state_d[e] = ST_FREE;
                        rdy_a_d[e] = 1'b0;
                        rdy_b_d[e] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Occupancy tracks the entry count: +1 alloc, -1 issue, net 0 for both.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (alloc_fire && !issue_fire) begin
            occ_d = occ_q + (IDX_W+1)'(1);
        end else if (!alloc_fire && issue_fire) begin
            occ_d = occ_q - (IDX_W+1)'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                state_q[e] <= ST_FREE;
            end
            rdy_a_q <= '0;
            rdy_b_q <= '0;
            occ_q   <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                state_q[e] <= state_d[e];
            end
            rdy_a_q <= rdy_a_d;
            rdy_b_q <= rdy_b_d;
            occ_q   <= occ_d;
        end
    end

    // NOTE: the tag storage is deliberately left out of reset. A FREE entry's
    // tags are never observed, and every alloc rewrites them, so resetting
    // them would only add reset fan-out to a plain data array.
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            tag_a_q[e] <= tag_a_d[e];
            tag_b_q[e] <= tag_b_d[e];
        end
    end

endmodule

// File: tb/tb_tag_wakeup_array.sv
// -----------------------------------------------------------------------------
// tb_tag_wakeup_array
//
// Self-checking bench for tag_wakeup_array. A behavioural reference model
// predicts the post-edge outputs of every driven cycle; the prediction is
// queued when stimulus is applied and compared after the edge. Directed
// scenarios add explicit expectations for reset, wakeup, bypass, full,
// priority/stall and flush, followed by a random phase.
// -----------------------------------------------------------------------------
module tb_tag_wakeup_array;

    localparam int TAG_W     = 6;
    localparam int ENTRIES   = 8;
    localparam int CDB_PORTS = 2;
    localparam int IDX_W     = 3;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       alloc_valid;
    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag_a;
    logic                       alloc_rdy_a;
    logic [TAG_W-1:0]           alloc_tag_b;
    logic                       alloc_rdy_b;
    logic [IDX_W-1:0]           alloc_idx;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [IDX_W-1:0]           issue_idx;
    logic [IDX_W:0]             occupancy;

    tag_wakeup_array #(
        .TAG_W     (TAG_W),
        .ENTRIES   (ENTRIES),
        .CDB_PORTS (CDB_PORTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_tag_a (alloc_tag_a),
        .alloc_rdy_a (alloc_rdy_a),
        .alloc_tag_b (alloc_tag_b),
        .alloc_rdy_b (alloc_rdy_b),
        .alloc_idx   (alloc_idx),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_idx   (issue_idx),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic             ar;
        logic [IDX_W-1:0] ai;
        logic             iv;
        logic [IDX_W-1:0] ii;
        logic [IDX_W:0]   occ;
    } exp_t;

    int               m_state [ENTRIES];   // 0 free, 1 wait, 2 ready
    logic [TAG_W-1:0] m_tag_a [ENTRIES];
    logic [TAG_W-1:0] m_tag_b [ENTRIES];
    bit               m_ra    [ENTRIES];
    bit               m_rb    [ENTRIES];
    exp_t             sb [$];

    function automatic bit m_hit(input logic [TAG_W-1:0] t);
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t m_outs();
        exp_t o;
        o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (m_state[i] == 0) begin
                o.ar = 1'b1;
                o.ai = IDX_W'(i);
            end
            if (m_state[i] == 2) begin
                o.iv = 1'b1;
                o.ii = IDX_W'(i);
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_state[i] != 0) o.occ = o.occ + 1'b1;
        end
        return o;
    endfunction

    task automatic m_step();
        exp_t o;
        bit   af;
        bit   isf;
        bit   ha;
        bit   hb;
        o   = m_outs();
        af  = alloc_valid && o.ar;
        isf = o.iv && issue_ready;
        ha  = m_hit(alloc_tag_a);
        hb  = m_hit(alloc_tag_b);
        if (rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) m_state[i] = 0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_state[i] == 1) begin
                    if (m_hit(m_tag_a[i])) m_ra[i] = 1'b1;
                    if (m_hit(m_tag_b[i])) m_rb[i] = 1'b1;
                    if (m_ra[i] && m_rb[i]) m_state[i] = 2;
                end
            end
            if (isf) m_state[o.ii] = 0;
            if (af) begin
                m_tag_a[o.ai] = alloc_tag_a;
                m_tag_b[o.ai] = alloc_tag_b;
                m_ra[o.ai]    = alloc_rdy_a || ha;
                m_rb[o.ai]    = alloc_rdy_b || hb;
                m_state[o.ai] = (m_ra[o.ai] && m_rb[o.ai]) ? 2 : 1;
            end
        end
    endtask

    // One clock: predict, queue the prediction, clock, pop and compare.
    task automatic cycle();
        exp_t e;
        m_step();
        sb.push_back(m_outs());
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("sb_alloc_ready", 32'(alloc_ready), 32'(e.ar));
        if (e.ar) check("sb_alloc_idx", 32'(alloc_idx), 32'(e.ai));
        check("sb_issue_valid", 32'(issue_valid), 32'(e.iv));
        if (e.iv) check("sb_issue_idx", 32'(issue_idx), 32'(e.ii));
        check("sb_occupancy", 32'(occupancy), 32'(e.occ));
    endtask

    task automatic idle();
        rst         = 1'b0;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_tag_a = '0;
        alloc_rdy_a = 1'b0;
        alloc_tag_b = '0;
        alloc_rdy_b = 1'b0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        issue_ready = 1'b0;
    endtask

    task automatic set_alloc(input logic [TAG_W-1:0] ta, input logic ra,
                             input logic [TAG_W-1:0] tb, input logic rb);
        alloc_valid = 1'b1;
        alloc_tag_a = ta;
        alloc_rdy_a = ra;
        alloc_tag_b = tb;
        alloc_rdy_b = rb;
    endtask

    task automatic set_cdb(input int port, input logic [TAG_W-1:0] t);
        cdb_valid[port]               = 1'b1;
        cdb_tag[port*TAG_W +: TAG_W]  = t;
    endtask

    // Watchdog: the bench is cycle-bounded, this only guards against a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_state[i] = 0;
            m_tag_a[i] = '0;
            m_tag_b[i] = '0;
            m_ra[i]    = 1'b0;
            m_rb[i]    = 1'b0;
        end
        idle();
        rst = 1'b1;
        @(negedge clk);

        // 1 Reset: two cycles of rst.
        rst = 1'b1; cycle();
        rst = 1'b1; cycle();
        idle();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_occupancy",   32'(occupancy),   32'd0);
        check("rst_alloc_idx",   32'(alloc_idx),   32'd0);
        check("rst_issue_idx",   32'(issue_idx),   32'd0);

        // 2 Wakeup via CDB port 0.
        idle(); set_alloc(6'd5, 1'b0, 6'd9, 1'b1); cycle();
        check("wk_wait_issue_valid", 32'(issue_valid), 32'd0);
        check("wk_wait_occupancy",   32'(occupancy),   32'd1);
        idle(); set_cdb(0, 6'd5); cycle();
        check("wk_issue_valid", 32'(issue_valid), 32'd1);
        check("wk_issue_idx",   32'(issue_idx),   32'd0);
        idle(); issue_ready = 1'b1; cycle();
        check("wk_occupancy_after_issue", 32'(occupancy), 32'd0);

        // 3 Bypass: both operands match CDB port 1 in the alloc cycle.
        idle(); set_alloc(6'd3, 1'b0, 6'd3, 1'b0); set_cdb(1, 6'd3); cycle();
        check("byp_issue_valid", 32'(issue_valid), 32'd1);
        check("byp_issue_idx",   32'(issue_idx),   32'd0);
        idle(); issue_ready = 1'b1; cycle();
        check("byp_drained", 32'(occupancy), 32'd0);

        // 4 Full and alloc/issue in the same cycle.
        for (int i = 0; i < ENTRIES; i++) begin
            check("full_alloc_idx", 32'(alloc_idx), 32'(i));
            idle(); set_alloc(6'(10 + i), 1'b0, 6'd0, 1'b1); cycle();
        end
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_occupancy",   32'(occupancy),   32'd8);
        idle(); set_alloc(6'd40, 1'b1, 6'd41, 1'b1); cycle();
        check("full_extra_ignored", 32'(occupancy), 32'd8);
        idle(); set_cdb(0, 6'd10); cycle();
        check("full_e0_ready", 32'(issue_idx), 32'd0);
        idle(); set_alloc(6'd42, 1'b1, 6'd43, 1'b1); issue_ready = 1'b1;
        check("full_pre_edge_alloc_ready", 32'(alloc_ready), 32'd0);
        cycle();
        check("full_post_alloc_ready", 32'(alloc_ready), 32'd1);
        check("full_post_alloc_idx",   32'(alloc_idx),   32'd0);
        check("full_post_occupancy",   32'(occupancy),   32'd7);
        idle(); flush = 1'b1; cycle();

        // 5 Priority and stall: entries 2 and 5 READY.
        for (int i = 0; i < 6; i++) begin
            idle();
            set_alloc(6'(20 + i), (i == 2 || i == 5), 6'(50 + i), 1'b1);
            cycle();
        end
        idle(); cycle();
        check("pri_hold_idx_a", 32'(issue_idx), 32'd2);
        idle(); cycle();
        check("pri_hold_idx_b", 32'(issue_idx), 32'd2);
        check("pri_hold_valid", 32'(issue_valid), 32'd1);
        idle(); issue_ready = 1'b1; set_alloc(6'd60, 1'b1, 6'd61, 1'b1); cycle();
        check("pri_next_idx",      32'(issue_idx), 32'd5);
        check("pri_net_occupancy", 32'(occupancy), 32'd6);
        idle(); issue_ready = 1'b1; cycle();
        check("pri_then_idx",  32'(issue_idx), 32'd6);
        check("pri_alloc_idx", 32'(alloc_idx), 32'd2);
        idle(); flush = 1'b1; cycle();

        // 6 Flush discards alloc, issue and wakeup.
        idle(); set_alloc(6'd1, 1'b1, 6'd2, 1'b1);   cycle();
        idle(); set_alloc(6'd30, 1'b0, 6'd2, 1'b1);  cycle();
        idle(); set_alloc(6'd1, 1'b1, 6'd2, 1'b1);   cycle();
        idle(); set_alloc(6'd1, 1'b1, 6'd31, 1'b0);  cycle();
        check("fl_pre_occupancy", 32'(occupancy), 32'd4);
        idle(); flush = 1'b1; issue_ready = 1'b1;
        set_alloc(6'd7, 1'b1, 6'd8, 1'b1); set_cdb(0, 6'd30); cycle();
        check("fl_occupancy",   32'(occupancy),   32'd0);
        check("fl_issue_valid", 32'(issue_valid), 32'd0);
        check("fl_alloc_idx",   32'(alloc_idx),   32'd0);

        // Random phase against the model; one reset in the middle.
        for (int c = 0; c < 600; c++) begin
            idle();
            rst         = (c == 300);
            flush       = ($urandom_range(0, 49) == 0);
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_tag_a = 6'($urandom_range(0, 7));
            alloc_tag_b = 6'($urandom_range(0, 7));
            alloc_rdy_a = ($urandom_range(0, 3) == 0);
            alloc_rdy_b = ($urandom_range(0, 3) == 0);
            cdb_valid   = 2'($urandom_range(0, 3));
            cdb_tag     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            issue_ready = ($urandom_range(0, 4) < 3);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
